// File: rtl/uart_const_baud_rx_if.sv
// Serial-receive bundle between the RX pin side and the byte consumer.
// The receiver drives through the slave modport; the environment through master.
interface uart_const_baud_rx_if;
  // rx_done is a valid-only strobe with no ready: the consumer must take rx_data
  // in the single cycle rx_done is high, as the receiver cannot be stalled.
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_idle;
  logic [2:0] state_dbg;

  modport master (
    output rx,
    input  rx_data, rx_done, frame_err, rx_idle, state_dbg
  );

  modport slave (
    input  rx,
    output rx_data, rx_done, frame_err, rx_idle, state_dbg
  );
endinterface

// File: rtl/uart_const_baud_rx.sv
// Fixed-baud 8N1 UART receiver: mid-bit sampling, one byte per frame with a 1-cycle strobe.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around each sample point, decisions 1 cycle later.
module uart_const_baud_rx #(
  parameter int unsigned clock_freq  = 100_000_000,
  parameter int unsigned baud_rate   = 115200,
  parameter int unsigned baud_limit  = clock_freq / baud_rate,
  parameter int unsigned limit_width = $clog2(baud_limit + 1)
) (
  input  logic                clk,
  input  logic                rst,
  uart_const_baud_rx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  localparam int unsigned HALF = baud_limit / 2;
  localparam logic [limit_width-1:0] CNT_ONE  = limit_width'(1);
  localparam logic [limit_width-1:0] CNT_LAST = limit_width'(baud_limit - 1);

  // The counter is cleared on the edge cycle E, so count k is seen at E+1+k.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [limit_width-1:0] START_HIT = limit_width'(HALF);
`else
  localparam logic [limit_width-1:0] START_HIT = limit_width'(HALF - 1);
`endif

  state_t                 state_q, state_d;
  logic [limit_width-1:0] cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   rx_s1_q, rx_s_q, rx_d_q;
  logic                   sample_bit;

`ifdef UART_RX_MAJORITY_EN
  logic rx_d2_q;

  always_ff @(posedge clk) begin
    if (rst) rx_d2_q <= 1'b1;
    else     rx_d2_q <= rx_d_q;
  end

  assign sample_bit = (rx_s_q & rx_d_q) | (rx_s_q & rx_d2_q) | (rx_d_q & rx_d2_q);
`else
  assign sample_bit = rx_s_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rx_s1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_d_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rx_s1_q <= bus.rx;
      rx_s_q  <= rx_s1_q;
      rx_d_q  <= rx_s_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rx_d_q && !rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == START_HIT) begin
          cnt_d   = '0;
          state_d = sample_bit ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {sample_bit, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        // Leaving at mid-stop gives half a bit of slack to catch a gapless next start.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (sample_bit) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_done   = done_q;
  assign bus.frame_err = err_q;
  assign bus.rx_idle   = (state_q == S_IDLE);
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_uart_const_baud_rx.sv
// Directed bench for uart_const_baud_rx at 10 clocks per bit.
// Build with UART_RX_MAJORITY_EN defined to exercise the voting receiver.
module tb_uart_const_baud_rx;

`ifdef UART_RX_MAJORITY_EN
  localparam int         LAT        = 99;
  localparam logic [7:0] GLITCH_EXP = 8'h0F;
`else
  localparam int         LAT        = 98;
  localparam logic [7:0] GLITCH_EXP = 8'h0D;
`endif
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  // clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_const_baud_rx_if bus ();

  uart_const_baud_rx #(
    .clock_freq(1_000_000),
    .baud_rate (100_000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int done_cyc[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.rx_done === 1'b1) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      got_q.push_back(bus.rx_data);
    end
    if (bus.frame_err === 1'b1) err_cnt++;
    if (bus.rx_done === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
  end

  // driver: start bit, 8 data bits LSB first, stop bit; rx left at stop value
  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input int glitch_bit, input int rst_bit, output int c0);
    logic v;
    c0 = cyc;
    for (int b = 0; b < 10; b++) begin
      if (b == 0)      v = 1'b0;
      else if (b == 9) v = stop;
      else             v = data[b-1];
      for (int k = 0; k < 10; k++) begin
        bus.rx = (glitch_bit >= 0 && b == glitch_bit + 1 && k == 5) ? ~v : v;
        rst    = (rst_bit >= 0 && b == rst_bit + 1 && k == 5);
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", bus.rx_data); end
    checks++; if (bus.rx_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.rx_done); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.frame_err); end
    checks++; if (bus.rx_idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b exp 1", bus.rx_idle); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single();
    int d0, e0, c0, lat;
    d0 = done_cnt; e0 = err_cnt;
    done_cyc.delete();
    send_frame(8'h55, 1'b1, -1, -1, c0);
    bus.rx = 1'b1;
    repeat (20) @(negedge clk);
    lat = (done_cyc.size() > 0) ? done_cyc[0] - c0 : -1;
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done_cnt got %0d exp 1", done_cnt - d0); end
    checks++; if (bus.rx_data !== 8'h55) begin errors++; $display("FAIL single_data got %h exp 55", bus.rx_data); end
    checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL single_err got %0d exp 0", err_cnt - e0); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL single_latency got %0d exp %0d", lat, LAT); end
    checks++; if (bus.rx_idle !== 1'b1) begin errors++; $display("FAIL single_idle got %b exp 1", bus.rx_idle); end
  endtask

  task automatic test_false_start();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    bus.rx = 1'b0;
    repeat (3) @(negedge clk);
    bus.rx = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (done_cnt - d0 != 0) begin errors++; $display("FAIL false_done got %0d exp 0", done_cnt - d0); end
    checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL false_err got %0d exp 0", err_cnt - e0); end
    checks++; if (bus.rx_idle !== 1'b1) begin errors++; $display("FAIL false_idle got %b exp 1", bus.rx_idle); end
    checks++; if (bus.rx_data !== 8'h55) begin errors++; $display("FAIL false_data got %h exp 55", bus.rx_data); end
  endtask

  task automatic test_back_to_back();
    int d0, c0, c1, gap;
    logic [7:0] g, e;
    d0 = done_cnt;
    got_q.delete();
    done_cyc.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_frame(8'hA5, 1'b1, -1, -1, c0);
    send_frame(8'h3C, 1'b1, -1, -1, c1);
    bus.rx = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done_cnt got %0d exp 2", done_cnt - d0); end
    for (int i = 0; i < 2; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_data%0d got %h exp %h", i, g, e); end
    end
    gap = (done_cyc.size() >= 2) ? done_cyc[1] - done_cyc[0] : -1;
    checks++; if (gap != 100) begin errors++; $display("FAIL b2b_gap got %0d exp 100", gap); end
  endtask

  task automatic test_frame_err();
    int d0, e0, c0;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h00, 1'b0, -1, -1, c0);
    bus.rx = 1'b0;
    repeat (50) @(negedge clk);
    checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL ferr_cnt got %0d exp 1", err_cnt - e0); end
    checks++; if (done_cnt - d0 != 0) begin errors++; $display("FAIL ferr_done got %0d exp 0", done_cnt - d0); end
    checks++; if (bus.rx_data !== 8'h3C) begin errors++; $display("FAIL ferr_data got %h exp 3c", bus.rx_data); end
    checks++; if (bus.state_dbg !== ST_WAIT_HIGH) begin errors++; $display("FAIL ferr_state got %0d exp %0d", bus.state_dbg, ST_WAIT_HIGH); end
    checks++; if (bus.rx_idle !== 1'b0) begin errors++; $display("FAIL ferr_busy got %b exp 0", bus.rx_idle); end
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (bus.rx_idle !== 1'b1) begin errors++; $display("FAIL ferr_release got %b exp 1", bus.rx_idle); end
    checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL ferr_repeat got %0d exp 1", err_cnt - e0); end
  endtask

  task automatic test_reset_mid();
    int d0, e0, c0;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'hF5, 1'b1, -1, 4, c0);
    bus.rx = 1'b1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (done_cnt - d0 != 0) begin errors++; $display("FAIL rstmid_done got %0d exp 0", done_cnt - d0); end
    checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL rstmid_err got %0d exp 0", err_cnt - e0); end
    checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h exp 00", bus.rx_data); end
    checks++; if (bus.rx_idle !== 1'b1) begin errors++; $display("FAIL rstmid_idle got %b exp 1", bus.rx_idle); end
    send_frame(8'hC3, 1'b1, -1, -1, c0);
    bus.rx = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL rstmid_next_cnt got %0d exp 1", done_cnt - d0); end
    checks++; if (bus.rx_data !== 8'hC3) begin errors++; $display("FAIL rstmid_next_data got %h exp c3", bus.rx_data); end
  endtask

  task automatic test_glitch();
    int d0, c0;
    d0 = done_cnt;
    send_frame(8'h0F, 1'b1, 1, -1, c0);
    bus.rx = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL glitch_cnt got %0d exp 1", done_cnt - d0); end
    checks++; if (bus.rx_data !== GLITCH_EXP) begin errors++; $display("FAIL glitch_data got %h exp %h", bus.rx_data, GLITCH_EXP); end
  endtask

  initial begin
    bus.rx = 1'b1;
    test_reset();
    test_single();
    test_false_start();
    test_back_to_back();
    test_frame_err();
    test_reset_mid();
    test_glitch();
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL exclusive_pulses got %0d exp 0", both_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
